mult_control: RTL

Control sequencer and 9-bit add/subtract datapath for the 8×8 signed add-shift multiplier. It sits directly upstream of `shift_unit`:
- It drives that unit's load, clear and shift strobes.
- It computes the next A/X values from the A register, the multiplier LSB and a captured copy of the switch operand S.
- One run takes 8 add/shift iterations, with a subtract on the last one. The product is left in A:B.

---
 rtl/mult_pkg.sv | 15 +
 rtl/add_sub_9.sv | 19 +
 rtl/mult_control.sv | 112 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the add-shift multiplier control block.
package mult_pkg;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned LAST_ITER = WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/add_sub_9.sv
// W-bit adder/subtractor: Sum = A + B, or A - B when Sub is high.
module add_sub_9 #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Sub,
  output logic [W-1:0] Sum
);

  logic [W-1:0] b_eff;

  // Subtract as invert-B plus carry-in; carry out of the MSB is dropped.
  always_comb begin
    b_eff = B ^ {W{Sub}};
    Sum   = A + b_eff + W'(Sub);
  end

endmodule

// File: rtl/mult_control.sv
// Control FSM for the signed add-shift multiplier: sequences clear/add/shift
// strobes to shift_unit and supplies the next A/X values.
module mult_control
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = mult_pkg::WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] A_in,
  input  logic             M,
  output logic             ClearA,
  output logic             LoadA,
  output logic             LoadX,
  output logic             LoadB,
  output logic             Shift_En,
  output logic [WIDTH-1:0] A_next,
  output logic             X_next,
  output logic             Done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned SUM_W = WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               ld_b_q, ld_b_d;
  logic               clb_seen_q, clb_seen_d;
  logic [SUM_W-1:0]   sum_c;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s_q        <= '0;
      ld_b_q     <= 1'b0;
      clb_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      ld_b_q     <= ld_b_d;
      clb_seen_q <= clb_seen_d;
    end
  end

  // ClearA_LoadB is a level; only its rising edge in IDLE yields a one-cycle load.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s_d        = s_q;
    ld_b_d     = 1'b0;
    clb_seen_d = ClearA_LoadB;
    ClearA     = ld_b_q;
    LoadB      = ld_b_q;
    LoadA      = 1'b0;
    LoadX      = 1'b0;
    Shift_En   = 1'b0;
    Done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (Run) begin
          state_d = CLEAR;
          s_d     = S;
        end else if (ClearA_LoadB && !clb_seen_q) begin
          ld_b_d = 1'b1;
        end
      end
      CLEAR: begin
        ClearA  = 1'b1;
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        LoadA   = M;
        LoadX   = M;
        state_d = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ADD;
        end
      end
      DONE: begin
        Done = 1'b1;
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Last iteration weighs the multiplier sign bit negatively, hence subtract.
  add_sub_9 #(.W(SUM_W)) u_add_sub (
    .A   ({A_in[WIDTH-1], A_in}),
    .B   ({s_q[WIDTH-1], s_q}),
    .Sub (cnt_q == CNT_LAST),
    .Sum (sum_c)
  );

  assign A_next = sum_c[WIDTH-1:0];
  assign X_next = sum_c[WIDTH];

endmodule
